// File: rtl/divsu_pkg.sv
// Shared types and constants for the iterative signed/unsigned divider.
package divsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } divsu_state_t;

  localparam int DIVSU_MAX_W = 64;

  // All-ones quotient returned on divide-by-zero, right-aligned to width w.
  function automatic logic [DIVSU_MAX_W-1:0] DIVSU_DZ_Q(input int w);
    return {DIVSU_MAX_W{1'b1}} >> (DIVSU_MAX_W - w);
  endfunction

endpackage

// File: rtl/divsu_mag.sv
// Combinational two's-complement conditional negate: magnitude at load, sign fix-up at the end.
module divsu_mag
  import divsu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/divsu_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
// Signed operand support is built only when DIVSU_SIGNED_EN is defined.
module divsu_iter
  import divsu_pkg::*;
#(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  input  logic                  sign,
  input  logic                  start,
  output logic [DIVIDEND_W-1:0] q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  busy,
  output logic                  done,
  output logic                  dz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0] DZ_Q = DIVIDEND_W'(DIVSU_DZ_Q(DIVIDEND_W));
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

  divsu_state_t            state;
  logic [CNT_W-1:0]        cnt;
  logic [DIVIDEND_W-1:0]   qreg;
  logic [DIVISOR_W-1:0]    rem;
  logic [DIVISOR_W-1:0]    bmag;
  logic                    neg_q;
  logic                    neg_r;
  logic                    dz_pend;

  logic                    neg_a_in;
  logic                    neg_b_in;
  logic [DIVIDEND_W-1:0]   amag_in;
  logic [DIVISOR_W-1:0]    bmag_in;
  logic [DIVIDEND_W-1:0]   qfix;
  logic [DIVISOR_W-1:0]    rfix;

`ifdef DIVSU_SIGNED_EN
  assign neg_a_in = sign & a[DIVIDEND_W-1];
  assign neg_b_in = sign & b[DIVISOR_W-1];
`else
  // Unsigned-only build: negate controls tie off and the mag units reduce to wires.
  logic sign_unused;
  assign sign_unused = sign;
  assign neg_a_in    = 1'b0;
  assign neg_b_in    = 1'b0;
`endif

  divsu_mag #(.W(DIVIDEND_W)) u_mag_a (.val(a),    .neg(neg_a_in), .res(amag_in));
  divsu_mag #(.W(DIVISOR_W))  u_mag_b (.val(b),    .neg(neg_b_in), .res(bmag_in));
  divsu_mag #(.W(DIVIDEND_W)) u_mag_q (.val(qreg), .neg(neg_q),    .res(qfix));
  divsu_mag #(.W(DIVISOR_W))  u_mag_r (.val(rem),  .neg(neg_r),    .res(rfix));

  // Partial remainder stays below bmag, so one extra bit is enough for the trial subtract.
  logic signed [DIVISOR_W:0] shifted;
  logic signed [DIVISOR_W:0] diff;
  logic                      ge;
  logic [DIVISOR_W-1:0]      rem_nxt;

  assign shifted = {rem, qreg[DIVIDEND_W-1]};
  assign diff    = shifted - $signed({1'b0, bmag});
  assign ge      = ~diff[DIVISOR_W];
  assign rem_nxt = ge ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            neg_q <= neg_a_in ^ neg_b_in;
            neg_r <= neg_a_in;
            rem   <= '0;
            bmag  <= bmag_in;
            if (b == '0) begin
              dz_pend <= 1'b1;
              qreg    <= a;
              state   <= FIX;
            end else begin
              dz_pend <= 1'b0;
              qreg    <= amag_in;
              cnt     <= CNT_LOAD;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          qreg <= {qreg[DIVIDEND_W-2:0], ge};
          rem  <= rem_nxt;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (dz_pend) begin
            q  <= DZ_Q;
            r  <= qreg[DIVISOR_W-1:0];
            dz <= 1'b1;
          end else begin
            q  <= qfix;
            r  <= rfix;
            dz <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
